// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one sample in, TAPS multiplies issued to an external
// pipelined multiplier, products accumulated, then rounded and saturated to 24 bits.
module fir_mac_seq #(
  parameter int TAPS      = 32,
  parameter int MUL_LAT   = 4,
  parameter int COEF_FRAC = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [23:0]       din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [34:0]       coef_wdata,
  output logic signed [23:0]       mul_a,
  output logic signed [34:0]       mul_b,
  input  logic signed [58:0]       mul_m,
  output logic signed [23:0]       dout,
  output logic                     dout_valid,
  output logic                     busy
);
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = 59 + AW;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'(8388607);
  localparam logic signed [ACC_W-1:0] YMIN = ACC_W'(-8388608);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} state_t;
  state_t state;

  logic signed [23:0]      delay [TAPS];
  logic signed [34:0]      coef  [TAPS];
  logic [AW-1:0]           wr_ptr, tap, nxt, rd_idx;
  logic signed [23:0]      sample;
  logic signed [ACC_W-1:0] acc, acc_rnd, y_full, prod_ext;
  logic signed [23:0]      y_sat;
  logic [MUL_LAT:0]        vld_pipe;

  assign din_ready = (state == IDLE);
  assign busy      = ~din_ready;
  assign nxt       = tap + 1'b1;
  assign rd_idx    = wr_ptr - nxt;
  assign prod_ext  = {{AW{mul_m[58]}}, mul_m};

  // Round half toward +inf, then clamp to the Q1.23 range.
  assign acc_rnd = acc + HALF;
  assign y_full  = acc_rnd >>> COEF_FRAC;
  assign y_sat   = (y_full > YMAX) ? 24'sh7FFFFF :
                   (y_full < YMIN) ? 24'sh800000 : y_full[23:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      tap        <= '0;
      sample     <= '0;
      acc        <= '0;
      vld_pipe   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      dout_valid            <= 1'b0;
      vld_pipe[MUL_LAT:1]   <= vld_pipe[MUL_LAT-1:0];
      if (vld_pipe[MUL_LAT]) acc <= acc + prod_ext;
      if (coef_we && state == IDLE) coef[coef_addr] <= coef_wdata;
      case (state)
        IDLE: if (din_valid) begin
          sample <= din;
          state  <= LOAD;
        end
        // Tap 0 is issued straight from the capture register since the
        // delay-line write lands at the end of this same cycle.
        LOAD: begin
          delay[wr_ptr] <= sample;
          acc           <= '0;
          tap           <= '0;
          mul_a         <= sample;
          mul_b         <= coef[0];
          vld_pipe[0]   <= 1'b1;
          state         <= MAC;
        end
        MAC: if (tap == LAST) begin
          mul_a       <= '0;
          mul_b       <= '0;
          vld_pipe[0] <= 1'b0;
          state       <= DRAIN;
        end else begin
          mul_a <= delay[rd_idx];
          mul_b <= coef[nxt];
          tap   <= nxt;
        end
        DRAIN: if (vld_pipe[MUL_LAT-1:0] == '0) state <= OUT;
        OUT: begin
          dout       <= y_sat;
          dout_valid <= 1'b1;
          wr_ptr     <= wr_ptr + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: pipelined multiplier model plus a convolution reference.
module tb_fir_mac_seq;
  localparam int TAPS = 32, MUL_LAT = 4, COEF_FRAC = 34;
  localparam int LAT = TAPS + MUL_LAT + 3;
  localparam int LIM = 80;

  logic clk = 1'b0, rst = 1'b1;
  logic signed [23:0] din = '0;
  logic din_valid = 1'b0, coef_we = 1'b0;
  logic [4:0] coef_addr = '0;
  logic signed [34:0] coef_wdata = '0;
  logic din_ready, dout_valid, busy;
  logic signed [23:0] mul_a, dout;
  logic signed [34:0] mul_b;
  logic signed [58:0] mul_m;
  logic signed [58:0] p_pipe [MUL_LAT];

  int n_vec = 0, n_err = 0;
  longint cm [TAPS];
  longint hist [$];
  logic signed [23:0] ra [LIM];
  logic signed [34:0] rb [LIM];
  logic rr [LIM];

  fir_mac_seq #(.TAPS(TAPS), .MUL_LAT(MUL_LAT), .COEF_FRAC(COEF_FRAC)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .dout(dout), .dout_valid(dout_valid), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p_pipe[0] <= 59'(longint'(mul_a) * longint'(mul_b));
    for (int k = 1; k < MUL_LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mul_m = p_pipe[MUL_LAT-1];

  // Direct-form convolution over every sample since reset.
  function automatic longint model_y();
    longint acc, y;
    acc = 0;
    for (int i = 0; i < TAPS; i++)
      if (i < hist.size()) acc += cm[i] * hist[hist.size()-1-i];
    y = (acc + (64'sd1 <<< (COEF_FRAC-1))) >>> COEF_FRAC;
    if (y > 8388607) y = 8388607;
    if (y < -8388608) y = -8388608;
    return y;
  endfunction

  function automatic longint tap_sample(input int i);
    int idx;
    idx = hist.size() - 1 - i;
    return (idx >= 0) ? hist[idx] : 64'sd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; coef_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    hist.delete();
    for (int i = 0; i < TAPS; i++) cm[i] = 0;
  endtask

  task automatic write_coef(input int a, input longint c);
    coef_we = 1'b1; coef_addr = 5'(a); coef_wdata = c[34:0];
    @(negedge clk);
    coef_we = 1'b0;
    cm[a] = c;
  endtask

  // Offers x (caller sits at a negedge) and follows it to its dout_valid.
  // wcyc>=0 pulses a write of wdat to coef[0] in that cycle of the run.
  task automatic run_sample(input logic signed [23:0] x, input bit hold, input int wcyc,
                            input longint wdat, output int lat, output int waited,
                            output logic signed [23:0] got, output longint exp_y);
    din = x; din_valid = 1'b1; waited = 0;
    while (!din_ready && waited < 100) begin @(negedge clk); waited++; end
    hist.push_back(longint'(x));
    if (wcyc == 0) begin
      coef_we = 1'b1; coef_addr = '0; coef_wdata = wdat[34:0]; cm[0] = wdat;
    end
    lat = -1; got = '0;
    for (int k = 1; k < LIM; k++) begin
      @(negedge clk);
      if (k == 1) begin coef_we = 1'b0; if (!hold) din_valid = 1'b0; end
      if (k == wcyc) begin coef_we = 1'b1; coef_addr = '0; coef_wdata = wdat[34:0]; end
      if (wcyc > 0 && k == wcyc + 1) coef_we = 1'b0;
      ra[k] = mul_a; rb[k] = mul_b; rr[k] = din_ready;
      if (dout_valid) begin lat = k; got = dout; break; end
    end
    exp_y = model_y();
  endtask

  task automatic test_reset();
    n_vec++; if (dout !== 24'sd0) begin n_err++; $display("FAIL reset_dout got=%0d want=0", dout); end
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid got=%b want=0", dout_valid); end
    n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++; if (mul_a !== 24'sd0) begin n_err++; $display("FAIL reset_mul_a got=%0d want=0", mul_a); end
    n_vec++; if (mul_b !== 35'sd0) begin n_err++; $display("FAIL reset_mul_b got=%0d want=0", mul_b); end
  endtask

  task automatic test_impulse();
    int want [7] = '{500, 0, 0, -250, 0, 0, 0};
    int lat, w; logic signed [23:0] got; longint e;
    do_reset();
    write_coef(0, 64'sd1 <<< 33);
    write_coef(3, -(64'sd1 <<< 32));
    for (int n = 0; n < 7; n++) begin
      run_sample((n == 0) ? 24'sd1000 : 24'sd0, 1'b0, -1, 0, lat, w, got, e);
      n_vec++; if (longint'(got) !== longint'(want[n])) begin
        n_err++; $display("FAIL impulse[%0d] got=%0d want=%0d", n, got, want[n]); end
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL impulse_lat[%0d] got=%0d want=%0d", n, lat, LAT); end
    end
  endtask

  task automatic test_rounding();
    logic signed [23:0] xs [3] = '{24'sd3, -24'sd3, 24'sd0};
    int want [3] = '{2, -1, 0};
    int lat, w; logic signed [23:0] got; longint e;
    do_reset();
    write_coef(0, 64'sd1 <<< 33);
    for (int n = 0; n < 3; n++) begin
      run_sample(xs[n], 1'b0, -1, 0, lat, w, got, e);
      n_vec++; if (longint'(got) !== longint'(want[n])) begin
        n_err++; $display("FAIL rounding[%0d] got=%0d want=%0d", n, got, want[n]); end
    end
  endtask

  task automatic test_saturation();
    int lat, w; logic signed [23:0] got; longint e;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, (64'sd1 <<< 34) - 1);
    for (int n = 0; n < 64; n++) begin
      run_sample((n < 32) ? 24'sh7FFFFF : 24'sh800000, 1'b0, -1, 0, lat, w, got, e);
      n_vec++; if (longint'(got) !== e) begin n_err++; $display("FAIL sat_model[%0d] got=%0d want=%0d", n, got, e); end
      if (n == 31) begin
        n_vec++; if (got !== 24'sh7FFFFF) begin n_err++; $display("FAIL sat_pos got=%0d want=8388607", got); end
      end
      if (n == 63) begin
        n_vec++; if (got !== 24'sh800000) begin n_err++; $display("FAIL sat_neg got=%0d want=-8388608", got); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, w, bad; logic signed [23:0] got; longint e; logic [63:0] r;
    logic signed [23:0] x;
    do_reset();
    for (int i = 0; i < TAPS; i++) begin
      r = {$urandom(), $urandom()};
      write_coef(i, longint'($signed(r[34:0])));
    end
    for (int n = 0; n < 40; n++) begin
      r = {32'd0, $urandom()};
      x = r[23:0];
      run_sample(x, 1'b1, -1, 0, lat, w, got, e);
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_lat[%0d] got=%0d want=%0d", n, lat, LAT); end
      n_vec++; if (w !== 0) begin n_err++; $display("FAIL b2b_gap[%0d] extra_wait=%0d want=0", n, w); end
      n_vec++; if (longint'(got) !== e) begin n_err++; $display("FAIL b2b_dout[%0d] got=%0d want=%0d", n, got, e); end
      bad = 0;
      for (int k = 1; k < LAT; k++) if (rr[k] !== 1'b0) bad++;
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_ready[%0d] high_cycles=%0d want=0", n, bad); end
      for (int i = 0; i < TAPS; i++) begin
        n_vec++; if (longint'(ra[2+i]) !== tap_sample(i)) begin
          n_err++; $display("FAIL b2b_mul_a[%0d] tap=%0d got=%0d want=%0d", n, i, ra[2+i], tap_sample(i)); end
        n_vec++; if (longint'(rb[2+i]) !== cm[i]) begin
          n_err++; $display("FAIL b2b_mul_b[%0d] tap=%0d got=%0d want=%0d", n, i, rb[2+i], cm[i]); end
      end
      bad = 0;
      for (int k = 1; k < LAT; k++)
        if ((k < 2 || k > TAPS + 1) && (ra[k] !== 24'sd0 || rb[k] !== 35'sd0)) bad++;
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_idle_ops[%0d] nonzero_cycles=%0d want=0", n, bad); end
    end
    din_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses, lat, w; logic signed [23:0] got; longint e;
    do_reset();
    write_coef(0, 64'sd1 <<< 33);
    pulses = 0;
    din = 24'sd5000; din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    for (int k = 2; k <= 10; k++) begin @(negedge clk); if (dout_valid) pulses++; end
    rst = 1'b1;
    #1;
    n_vec++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%b want=1", din_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_vec++; if (mul_a !== 24'sd0) begin n_err++; $display("FAIL midrst_mul_a got=%0d want=0", mul_a); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    for (int i = 0; i < TAPS; i++) cm[i] = 0;
    for (int k = 0; k < 45; k++) begin @(negedge clk); if (dout_valid) pulses++; end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_pulses got=%0d want=0", pulses); end
    n_vec++; if (dout !== 24'sd0) begin n_err++; $display("FAIL midrst_dout got=%0d want=0", dout); end
    write_coef(0, 64'sd1 <<< 33);
    run_sample(24'sd1000, 1'b0, -1, 0, lat, w, got, e);
    n_vec++; if (got !== 24'sd500) begin n_err++; $display("FAIL midrst_after got=%0d want=500", got); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL midrst_lat got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_coef_busy();
    int lat, w; logic signed [23:0] got; longint e;
    do_reset();
    write_coef(0, 64'sd1 <<< 33);
    run_sample(24'sd777, 1'b0, 5, (64'sd1 <<< 34) - 1, lat, w, got, e);
    n_vec++; if (got !== 24'sd389) begin n_err++; $display("FAIL busy_write_run got=%0d want=389", got); end
    run_sample(24'sd1000, 1'b0, -1, 0, lat, w, got, e);
    n_vec++; if (got !== 24'sd500) begin n_err++; $display("FAIL busy_write_dropped got=%0d want=500", got); end
    run_sample(24'sd1000, 1'b0, 0, 64'sd1 <<< 32, lat, w, got, e);
    n_vec++; if (got !== 24'sd250) begin n_err++; $display("FAIL handshake_write got=%0d want=250", got); end
    n_vec++; if (longint'(got) !== e) begin n_err++; $display("FAIL handshake_write_model got=%0d want=%0d", got, e); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_coef_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
